// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: column drive patterns, debounce FSM states and the
// matrix-index to hex-code map.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StPressed,
        StRelease
    } key_state_e;

    // Active-low one-hot drive for the selected column.
    function automatic logic [3:0] col_drive(input logic [1:0] col);
        col_drive = ~(4'b0001 << col);
    endfunction

    // Index is row*4+col; bottom row carries '*'=E and '#'=F.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        case (idx)
            4'd0:    key_map = 4'h1;
            4'd1:    key_map = 4'h2;
            4'd2:    key_map = 4'h3;
            4'd3:    key_map = 4'hA;
            4'd4:    key_map = 4'h4;
            4'd5:    key_map = 4'h5;
            4'd6:    key_map = 4'h6;
            4'd7:    key_map = 4'hB;
            4'd8:    key_map = 4'h7;
            4'd9:    key_map = 4'h8;
            4'd10:   key_map = 4'h9;
            4'd11:   key_map = 4'hC;
            4'd12:   key_map = 4'hE;
            4'd13:   key_map = 4'h0;
            4'd14:   key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-frame debounce FSM: candidate register, saturating frame counter and
// press/release acceptance.
module keypad_debounce
    import keypad_scanner_pkg::*;
#(
    parameter logic [7:0] DEBOUNCE_SCANS = 8'd20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_end,
    input  logic       key_found,
    input  logic [3:0] key_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [7:0] Thresh = (DEBOUNCE_SCANS == 8'd0) ? 8'd1 : DEBOUNCE_SCANS;

    key_state_e state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] code_q, code_d;
    logic [7:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       held_q, held_d;
    logic [7:0] cnt_inc;

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (key_found) begin
                        state_d = StDebounce;
                        cand_d  = key_in;
                        cnt_d   = 8'd1;
                    end
                end
                StDebounce: begin
                    if (!key_found) begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end else if (key_in == cand_q) begin
                        cnt_d = cnt_inc;
                    end else begin
                        cand_d = key_in;
                        cnt_d  = 8'd1;
                    end
                end
                StPressed: begin
                    if (key_found) begin
                        cnt_d = 8'd0;
                    end else begin
                        state_d = StRelease;
                        cnt_d   = 8'd1;
                    end
                end
                StRelease: begin
                    if (key_found) begin
                        state_d = StPressed;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            endcase
            // Threshold checked on the updated count so a threshold of 1 accepts at once.
            if (state_d == StDebounce && cnt_d >= Thresh) begin
                state_d = StPressed;
                code_d  = cand_d;
                valid_d = 1'b1;
                held_d  = 1'b1;
                cnt_d   = 8'd0;
            end
            if (state_d == StRelease && cnt_d >= Thresh) begin
                state_d = StIdle;
                held_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cand_q  <= 4'h0;
            code_q  <= 4'h0;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column ring, row synchronizer and per-frame
// priority encoder feeding the debounce FSM.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV       = 16'd49_999,
    parameter logic [7:0]  DEBOUNCE_SCANS = 8'd20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    logic [3:0]  row_meta_q, row_sync_q;
    logic [15:0] div_q;
    logic [1:0]  col_q;
    logic [15:0] frame_keys_q;
    logic [15:0] col_hits, frame_all;
    logic        sample, frame_end, key_found;
    logic [3:0]  key_idx;

    assign sample    = (div_q == SCAN_DIV);
    assign frame_end = sample && (col_q == 2'd3);

    // Bitmap bit row*4+col marks a key seen pressed in this frame.
    always_comb begin
        col_hits = '0;
        if (sample) begin
            for (int unsigned r = 0; r < 4; r++) begin
                col_hits[{r[1:0], col_q}] = ~row_sync_q[r];
            end
        end
    end

    assign frame_all = frame_keys_q | col_hits;

    always_comb begin
        key_found = 1'b0;
        key_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (frame_all[i]) begin
                key_found = 1'b1;
                key_idx   = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_q   <= 4'hF;
            row_sync_q   <= 4'hF;
            div_q        <= 16'd0;
            col_q        <= 2'd0;
            frame_keys_q <= '0;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
            if (sample) begin
                div_q        <= 16'd0;
                col_q        <= col_q + 2'd1;
                frame_keys_q <= frame_end ? '0 : frame_all;
            end else begin
                div_q <= div_q + 16'd1;
            end
        end
    end

    assign col_out = col_drive(col_q);

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .frame_end(frame_end),
        .key_found(key_found),
        .key_in   (key_map(key_idx)),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-level bench for keypad_scanner with SCAN_DIV=3, DEBOUNCE_SCANS=3.
module tb_keypad_scanner;

    localparam int DebScans = 3;
    localparam int FrameClks = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;

    logic [3:0] code_tab [16];
    bit         m_held;
    logic [3:0] m_code;
    int         m_run_key;
    int         m_run_len;
    int         m_empty_run;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV      (16'd3),
        .DEBOUNCE_SCANS(8'd3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Physical keypad: a pressed key shorts its row to any column driven low.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_out[c] && pressed[r*4+c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_held      = 1'b0;
        m_code      = 4'h0;
        m_run_key   = -1;
        m_run_len   = 0;
        m_empty_run = 0;
    endtask

    // Lowest pressed index wins; press needs DebScans identical frames, release
    // needs DebScans empty frames; nothing new is accepted while held.
    task automatic model_frame(input logic [15:0] s, output bit pulse);
        int idx;
        idx = -1;
        for (int i = 15; i >= 0; i--) if (s[i]) idx = i;
        pulse = 1'b0;
        if (!m_held) begin
            if (idx < 0) m_run_len = 0;
            else if (m_run_len > 0 && idx == m_run_key) m_run_len++;
            else begin
                m_run_key = idx;
                m_run_len = 1;
            end
            if (m_run_len >= DebScans) begin
                m_held    = 1'b1;
                m_code    = code_tab[m_run_key];
                pulse     = 1'b1;
                m_run_len = 0;
            end
        end else begin
            if (idx < 0) m_empty_run++;
            else m_empty_run = 0;
            if (m_empty_run >= DebScans) begin
                m_held      = 1'b0;
                m_empty_run = 0;
            end
        end
    endtask

    // Called on the negedge that starts a frame; ends on the negedge after its last edge.
    task automatic run_frame(input logic [15:0] keys, input string tag);
        int         pulses;
        bit         exp_pulse;
        logic [3:0] exp_col;
        pressed = keys;
        pulses  = 0;
        for (int k = 1; k <= FrameClks; k++) begin
            @(negedge clk);
            if (key_valid) pulses++;
            if (k % 4 == 0) begin
                exp_col = ~(4'b0001 << ((k / 4) % 4));
                check_eq({tag, "_col"}, 32'(col_out), 32'(exp_col));
            end
        end
        model_frame(keys, exp_pulse);
        check_eq({tag, "_pulses"}, 32'(pulses), 32'(exp_pulse));
        check_eq({tag, "_held"}, 32'(key_held), 32'(m_held));
        check_eq({tag, "_code"}, 32'(key_code), 32'(m_code));
    endtask

    task automatic repeat_frames(input logic [15:0] keys, input int n, input string tag);
        for (int i = 0; i < n; i++) run_frame(keys, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rcol"}, 32'(col_out), 32'h E);
        check_eq({tag, "_rcode"}, 32'(key_code), 32'h0);
        check_eq({tag, "_rvalid"}, 32'(key_valid), 32'h0);
        check_eq({tag, "_rheld"}, 32'(key_held), 32'h0);
    endtask

    initial begin
        logic [15:0] keys;
        int          len;
        int          n;
        code_tab = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                     4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        model_reset();
        pressed = '0;
        rst     = 1'b0;
        #2;
        check_reset_outputs("t1");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        repeat_frames(16'h0000, 2, "t1_idle");

        repeat_frames(16'h0020, 4, "t2_press5");
        check_eq("t2_code5", 32'(key_code), 32'h5);
        check_eq("t2_held", 32'(key_held), 32'h1);
        repeat_frames(16'h0000, 4, "t2_release");
        check_eq("t2_released", 32'(key_held), 32'h0);

        run_frame(16'h0020, "t3_bounce");
        run_frame(16'h0000, "t3_gap");
        repeat_frames(16'h0020, 4, "t3_steady");
        repeat_frames(16'h0000, 4, "t3_release");

        repeat_frames(16'h0401, 4, "t4_1and9");
        check_eq("t4_code1", 32'(key_code), 32'h1);
        repeat_frames(16'h0000, 4, "t4_release");

        repeat_frames(16'h2000, 4, "t5_hold0");
        repeat_frames(16'hA000, 2, "t5_add_d");
        repeat_frames(16'h8000, 4, "t5_only_d");
        check_eq("t5_code0", 32'(key_code), 32'h0);
        check_eq("t5_held", 32'(key_held), 32'h1);
        repeat_frames(16'h0000, 4, "t5_release");

        repeat_frames(16'h0100, 4, "t6_hold7");
        check_eq("t6_held_before", 32'(key_held), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("t6");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat_frames(16'h0100, 4, "t6_after");
        check_eq("t6_code7", 32'(key_code), 32'h7);
        repeat_frames(16'h0000, 4, "t6_release");

        n = 0;
        while (n < 60) begin
            case ($urandom_range(0, 3))
                0: keys = 16'h0000;
                1, 2: keys = 16'd1 << $urandom_range(0, 15);
                default: keys = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            endcase
            len = int'($urandom_range(1, 5));
            repeat_frames(keys, len, "rand");
            n += len;
        end
        repeat_frames(16'h0000, 4, "rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
